// File: rtl/reg_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// reg_wr_arbiter_pkg
// Core constants shared by the register-file write path.
//   XLEN   : integer data width
//   NREG   : number of architectural registers
//   AW     : register index width (2**AW must be >= NREG)
//   X0_IDX : index of the hard-wired zero register
// Also provides the grant enum and a small x0 test helper.
// ----------------------------------------------------------------------------
package reg_wr_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int AW     = 5;
   localparam int X0_IDX = 0;

   // Identifies which requester was granted most recently.
   typedef enum logic {
      GNT_REQ0 = 1'b0,
      GNT_REQ1 = 1'b1
   } gnt_e;

   // True when the register index addresses x0.
   function automatic logic addr_is_x0(input logic [AW-1:0] addr);
      return (addr == AW'(X0_IDX));
   endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_wr_arbiter_if
// Bus between the two write requesters, the arbiter and the register file.
//   req0_*   : writeback-stage request (valid/ready/addr/data)
//   req1_*   : multi-cycle-unit request (valid/ready/addr/data)
//   rf_hold  : freezes register-file writes
//   rf_wen   : one-hot per-register write enable
//   rf_wdata : write data broadcast to all register cells
//   byp_*    : forwarding view of the buffered write (only with
//              REG_WR_ARB_BYPASS_EN defined)
// Modports: master = requesters / register-file side, slave = arbiter.
// ----------------------------------------------------------------------------
interface reg_wr_arbiter_if;
   import reg_wr_arbiter_pkg::*;

   logic            req0_valid;
   logic            req0_ready;
   logic [AW-1:0]   req0_addr;
   logic [XLEN-1:0] req0_data;
   logic            req1_valid;
   logic            req1_ready;
   logic [AW-1:0]   req1_addr;
   logic [XLEN-1:0] req1_data;
   logic            rf_hold;
   logic [NREG-1:0] rf_wen;
   logic [XLEN-1:0] rf_wdata;
`ifdef REG_WR_ARB_BYPASS_EN
   logic            byp_valid;
   logic [AW-1:0]   byp_addr;
   logic [XLEN-1:0] byp_data;
`endif

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output rf_hold,
`ifdef REG_WR_ARB_BYPASS_EN
      input  byp_valid, byp_addr, byp_data,
`endif
      input  req0_ready, req1_ready, rf_wen, rf_wdata
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  rf_hold,
`ifdef REG_WR_ARB_BYPASS_EN
      output byp_valid, byp_addr, byp_data,
`endif
      output req0_ready, req1_ready, rf_wen, rf_wdata
   );

endinterface

// File: rtl/reg_wr_arbiter_decode.sv
// ----------------------------------------------------------------------------
// reg_wr_decode
// Combinational index-to-one-hot write-enable decoder with x0 masking.
// Indices at or above NREG decode to all-zero. Reusable for the CSR port.
//   en   : global enable
//   addr : register index
//   wen  : one-hot write enable (never sets bit X0_IDX)
// ----------------------------------------------------------------------------
module reg_wr_decode #(
   parameter int AW     = 5,
   parameter int NREG   = 32,
   parameter int X0_IDX = 0
) (
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [NREG-1:0] wen
);

   // One-hot decode; the x0 cell never sees a write enable.
   always_comb begin
      wen = {NREG{1'b0}};
      for (int k = 0; k < NREG; k++) begin
         if (en && (addr == AW'(k)) && (k != X0_IDX)) begin
            wen[k] = 1'b1;
         end else begin
            wen[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wr_arbiter
// Round-robin arbiter and one-stage write buffer for the single integer
// register-file write port. Requester 0 is writeback, requester 1 is the
// multi-cycle unit. An accepted write appears on rf_wen one cycle later.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : reg_wr_arbiter_if.slave (requests, rf_hold, rf_wen, rf_wdata)
// Optional: define REG_WR_ARB_BYPASS_EN to drive bus.byp_* forwarding outputs.
// ----------------------------------------------------------------------------
module reg_wr_arbiter
   import reg_wr_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   reg_wr_arbiter_if.slave  bus
);

   gnt_e            last_gnt_r;
   logic            out_valid_r;
   logic [AW-1:0]   out_addr_r;
   logic [XLEN-1:0] out_data_r;

   logic            grant0_s;
   logic            grant1_s;
   logic            ready0_s;
   logic            ready1_s;
   logic            acc0_s;
   logic            acc1_s;
   logic            wen_en_s;
   logic [NREG-1:0] wen_s;

   // Round-robin grant: on contention the requester not granted last wins.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (last_gnt_r == GNT_REQ1) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (bus.req0_valid) begin
         grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Readies are suppressed during hold and while reset is applied.
   assign ready0_s = grant0_s & ~bus.rf_hold & ~rst;
   assign ready1_s = grant1_s & ~bus.rf_hold & ~rst;
   assign acc0_s   = bus.req0_valid & ready0_s;
   assign acc1_s   = bus.req1_valid & ready1_s;

   assign bus.req0_ready = ready0_s;
   assign bus.req1_ready = ready1_s;

   // Grant history and write buffer; hold freezes both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_r  <= GNT_REQ1;
         out_valid_r <= 1'b0;
         out_addr_r  <= {AW{1'b0}};
         out_data_r  <= {XLEN{1'b0}};
      end else if (bus.rf_hold) begin
         last_gnt_r  <= last_gnt_r;
         out_valid_r <= out_valid_r;
         out_addr_r  <= out_addr_r;
         out_data_r  <= out_data_r;
      end else if (acc0_s) begin
         last_gnt_r  <= GNT_REQ0;
         out_valid_r <= 1'b1;
         out_addr_r  <= bus.req0_addr;
         out_data_r  <= bus.req0_data;
      end else if (acc1_s) begin
         last_gnt_r  <= GNT_REQ1;
         out_valid_r <= 1'b1;
         out_addr_r  <= bus.req1_addr;
         out_data_r  <= bus.req1_data;
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   // The buffered write fires only while the register file is not held.
   assign wen_en_s = out_valid_r & ~bus.rf_hold;

   reg_wr_decode #(
      .AW     (AW),
      .NREG   (NREG),
      .X0_IDX (X0_IDX)
   ) u_decode (
      .en   (wen_en_s),
      .addr (out_addr_r),
      .wen  (wen_s)
   );

   assign bus.rf_wen   = wen_s;
   assign bus.rf_wdata = out_data_r;

`ifdef REG_WR_ARB_BYPASS_EN
   // x0 writes are never forwarded: reads of x0 must still return zero.
   assign bus.byp_valid = out_valid_r & ~addr_is_x0(out_addr_r);
   assign bus.byp_addr  = out_addr_r;
   assign bus.byp_data  = out_data_r;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_wr_arbiter
// Self-checking bench for reg_wr_arbiter: directed stimulus with literal
// expectations plus a transaction-level model compared every cycle.
// ----------------------------------------------------------------------------
module tb_reg_wr_arbiter;
   import reg_wr_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_total = 0;
   int n_pass  = 0;

   reg_wr_arbiter_if bus ();

   reg_wr_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Pending write = the one accepted most recently and not yet retired.
   int              m_last  = 1;
   bit              m_valid = 1'b0;
   logic [AW-1:0]   m_addr  = '0;
   logic [XLEN-1:0] m_data  = '0;
   int              m_win;

   // Which requester (0/1) gets the port now, or -1 for none.
   function automatic int pick(input bit v0, input bit v1, input int last);
      if (v0 && v1) return 1 - last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always_comb m_win = (rst || bus.rf_hold) ? -1 : pick(bus.req0_valid, bus.req1_valid, m_last);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0; m_addr <= '0; m_data <= '0; m_last <= 1;
      end else if (!bus.rf_hold) begin
         if (m_win == 0) begin
            m_valid <= 1'b1; m_addr <= bus.req0_addr; m_data <= bus.req0_data; m_last <= 0;
         end else if (m_win == 1) begin
            m_valid <= 1'b1; m_addr <= bus.req1_addr; m_data <= bus.req1_data; m_last <= 1;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   function automatic logic [NREG-1:0] exp_wen();
      logic [NREG-1:0] one;
      one = {{(NREG-1){1'b0}}, 1'b1};
      if (m_valid && !bus.rf_hold && rst == 1'b0 && int'(m_addr) != X0_IDX && int'(m_addr) < NREG)
         return one << m_addr;
      return '0;
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cmp_ready0", 32'(bus.req0_ready), 32'(m_win == 0));
      chk("cmp_ready1", 32'(bus.req1_ready), 32'(m_win == 1));
      chk("cmp_wen",    32'(bus.rf_wen),     32'(exp_wen()));
      chk("cmp_wdata",  bus.rf_wdata,        m_data);
`ifdef REG_WR_ARB_BYPASS_EN
      chk("cmp_byp_valid", 32'(bus.byp_valid), 32'(m_valid && m_addr != '0));
      chk("cmp_byp_addr",  32'(bus.byp_addr),  32'(m_addr));
      chk("cmp_byp_data",  bus.byp_data,       m_data);
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
   endtask

   task automatic drv1(input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
   endtask

   initial begin
      bit          r0_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] wen_tab[4] = '{32'h2, 32'h4, 32'h2, 32'h4};

      bus.rf_hold = 1'b0;
      drv1(1'b0, 5'd0, 32'h0);
      drv0(1'b1, 5'd5, 32'hDEADBEEF);

      // Reset state: no ready even with a valid request, outputs zero.
      @(negedge clk);
      chk("rst_ready0", 32'(bus.req0_ready), 32'h0);
      chk("rst_wen",    32'(bus.rf_wen),     32'h0);
      chk("rst_wdata",  bus.rf_wdata,        32'h0);
      tick(); rst = 1'b0;

      // Single write to x5.
      @(negedge clk);
      chk("single_ready0", 32'(bus.req0_ready), 32'h1);
      tick(); drv0(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("single_wen",   32'(bus.rf_wen), 32'h0000_0020);
      chk("single_wdata", bus.rf_wdata,    32'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("single_wen_off", 32'(bus.rf_wen), 32'h0);

      // Contention straight after reset: 0,1,0,1.
      rst = 1'b1; tick(); rst = 1'b0;
      drv0(1'b1, 5'd1, 32'h1111_1111);
      drv1(1'b1, 5'd2, 32'h2222_2222);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("cont_ready0", 32'(bus.req0_ready), 32'(r0_tab[i]));
         chk("cont_ready1", 32'(bus.req1_ready), 32'(!r0_tab[i]));
         if (i > 0) chk("cont_wen", 32'(bus.rf_wen), wen_tab[i-1]);
         tick();
      end
      drv0(1'b0, 5'd0, 32'h0); drv1(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("cont_wen_last", 32'(bus.rf_wen), wen_tab[3]);

      // x0 write via req1 after a req0 write; it must still consume a grant.
      drv0(1'b1, 5'd4, 32'h4444_4444);
      tick(); drv0(1'b0, 5'd0, 32'h0); drv1(1'b1, 5'd0, 32'h12345678);
      @(negedge clk);
      chk("x0_ready1", 32'(bus.req1_ready), 32'h1);
      chk("x0_prev_wen", 32'(bus.rf_wen), 32'h0000_0010);
      tick(); drv1(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("x0_wen",   32'(bus.rf_wen), 32'h0);
      chk("x0_wdata", bus.rf_wdata,    32'h12345678);
      drv0(1'b1, 5'd1, 32'h1111_1111); drv1(1'b1, 5'd2, 32'h2222_2222);
      #1;
      chk("x0_then_ready0", 32'(bus.req0_ready), 32'h1);
      chk("x0_then_ready1", 32'(bus.req1_ready), 32'h0);
      tick(); drv0(1'b0, 5'd0, 32'h0); drv1(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("x0_then_wen", 32'(bus.rf_wen), 32'h2);

      // Hold with a buffered write to x7 and both requesters waiting.
      drv0(1'b1, 5'd7, 32'h7777_7777);
      tick();
      bus.rf_hold = 1'b1;
      drv0(1'b1, 5'd8, 32'h8888_8888); drv1(1'b1, 5'd10, 32'hAAAA_AAAA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_ready0", 32'(bus.req0_ready), 32'h0);
         chk("hold_ready1", 32'(bus.req1_ready), 32'h0);
         chk("hold_wen",    32'(bus.rf_wen),     32'h0);
         tick();
      end
      bus.rf_hold = 1'b0;
      @(negedge clk);
      chk("release_wen",    32'(bus.rf_wen), 32'h0000_0080);
      chk("release_wdata",  bus.rf_wdata,    32'h7777_7777);
      chk("release_ready1", 32'(bus.req1_ready), 32'h1);
      tick(); drv1(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("release_next_wen", 32'(bus.rf_wen), 32'h0000_0400);
      chk("release_ready0",   32'(bus.req0_ready), 32'h1);
      tick(); drv0(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("release_x8_wen", 32'(bus.rf_wen), 32'h0000_0100);

      // Reset while a write to x9 sits in the buffer.
      drv0(1'b1, 5'd9, 32'h9999_9999);
      tick();
      chk("midrst_pre_wen", 32'(bus.rf_wen), 32'h0000_0200);
      rst = 1'b1; drv0(1'b0, 5'd0, 32'h0);
      #1;
      chk("midrst_wen",   32'(bus.rf_wen), 32'h0);
      chk("midrst_wdata", bus.rf_wdata,    32'h0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("midrst_after_wen", 32'(bus.rf_wen), 32'h0);
      drv0(1'b1, 5'd1, 32'h1111_1111); drv1(1'b1, 5'd2, 32'h2222_2222);
      #1;
      chk("midrst_ready0", 32'(bus.req0_ready), 32'h1);
      chk("midrst_ready1", 32'(bus.req1_ready), 32'h0);
      tick(); drv0(1'b0, 5'd0, 32'h0); drv1(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("midrst_cont_wen", 32'(bus.rf_wen), 32'h2);

`ifdef REG_WR_ARB_BYPASS_EN
      // Forwarding view of the buffered write.
      drv0(1'b1, 5'd3, 32'hA5A5_A5A5);
      tick(); drv0(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("byp_wen",   32'(bus.rf_wen),    32'h0000_0008);
      chk("byp_valid", 32'(bus.byp_valid), 32'h1);
      chk("byp_addr",  32'(bus.byp_addr),  32'h3);
      chk("byp_data",  bus.byp_data,       32'hA5A5_A5A5);
      drv0(1'b1, 5'd0, 32'h5A5A_5A5A);
      tick(); drv0(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("byp_x0_valid", 32'(bus.byp_valid), 32'h0);
`endif

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Two-requester arbiter and sequencer for the single write port of the integer register file, which is built from per-register R/W cells with a write enable.
- Requester 0 is the pipeline writeback stage; requester 1 is the multi-cycle unit (load/div).
- Uses round-robin grant, a one-stage registered write buffer, and a one-hot decode that drives each register cell's write enable.
- Sits between the writeback stage and the register file.

Parameters:
- XLEN, 32, data width; the value comes from the shared core constants.
- NREG, 32, number of architectural registers.
- AW, 5, register address width; must satisfy 2^AW >= NREG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  writeback-stage write request.
- req0_ready  out  1  writeback-stage request accepted this cycle.
- req0_addr  in  AW  destination register index.
- req0_data  in  XLEN  write data.
- req1_valid  in  1  multi-cycle-unit write request.
- req1_ready  out  1  multi-cycle-unit request accepted this cycle.
- req1_addr  in  AW  destination register index.
- req1_data  in  XLEN  write data.
- rf_hold  in  1  freeze register-file writes (debug halt / stall).
- rf_wen  out  NREG  one-hot per-register write enable.
- rf_wdata  out  XLEN  data broadcast to all register cells.

Behaviour:
- Handshake
  - A transfer on requester i occurs when reqi_valid & reqi_ready at a rising clk edge.
  - Once asserted, reqi_valid and its payload stay stable until accepted.
  - reqi_ready is combinational: reqi_ready = grant_i & ~rf_hold.
  - reqi_ready may depend on the other requester's valid.
- Arbitration
  - One bit of state: last_gnt.
  - Exactly one valid requester: that requester is granted.
  - Both valid: grant the requester != last_gnt.
  - Neither valid: no grant.
  - last_gnt updates to the granted index on every accepted transfer only.
  - Reset value: last_gnt = 1, so requester 0 wins the first contention.
- Buffer stage
  - Registers: out_valid, out_addr, out_data.
  - An accepted transfer loads the stage on the same edge.
  - No accept and not held: out_valid clears.
  - rf_hold = 1: the stage holds its contents and no new request is accepted.
- Output
  - rf_wen[k] = out_valid & ~rf_hold & (out_addr == k) & (k != 0).
  - rf_wdata = out_data.
  - Latency from request acceptance to rf_wen is 1 cycle; throughput is 1 write per cycle.
- Register x0
  - Writes to address 0 complete the handshake normally.
  - They produce an all-zero rf_wen.
  - They still consume a grant.
- Out-of-range addresses (out_addr >= NREG): accepted, rf_wen all zero.
- Hold release: a write held in the stage fires rf_wen on the first cycle rf_hold is low. A new transfer can be accepted in that same cycle.
- Reset values (asynchronous, immediate on rst high)
  - out_valid = 0, out_addr = 0, out_data = 0, last_gnt = 1.
  - rf_wen = 0, rf_wdata = 0.
  - Readies are 0 while rst is high.
  - Reset mid-operation discards any buffered write; no partial write occurs.

Optional Feature:
- Macro: REG_WR_ARB_BYPASS_EN.
- Defined: adds outputs byp_valid (1), byp_addr (AW) and byp_data (XLEN), each equal to out_valid, out_addr and out_data. byp_valid is forced to 0 when out_addr == 0. Operand read logic uses these to forward a write not yet visible in the register file.
- Undefined: these ports and their logic are absent; the read stage must stall one cycle after a dependent write.

Decomposition:
- Shared core package/header: XLEN, NREG, AW, and the x0 index constant.
- One natural sub-module, reg_wr_decode: combinational AW-to-NREG one-hot decoder with enable and x0 mask. Reusable for the CSR write port.
- The arbiter and buffer stage stay in the top module.

Test Plan:
- Single write: req0 writes addr 5, data 0xDEADBEEF. Expect req0_ready=1 on the same cycle; on the next cycle rf_wen=0x00000020 and rf_wdata=0xDEADBEEF for exactly 1 cycle.
- Contention: both requests valid for 4 cycles (req0 addr 1, req1 addr 2) after reset. Expect grant order 0,1,0,1 and rf_wen sequence bit1, bit2, bit1, bit2 on consecutive cycles.
- x0 write: req1 writes addr 0, data 0x12345678. Expect the handshake completes, rf_wen stays 0, and last_gnt becomes 1.
- Hold: accept addr 7, then rf_hold=1 for 3 cycles. Expect rf_wen=0 and both readies 0 during hold. On release, expect rf_wen bit7 with the original data in the first low cycle, with a new accept allowed in that same cycle.
- Reset mid-op: assert rst while out_valid=1 (addr 9). Expect rf_wen=0 immediately and no write after deassertion; the next contention grants req0 first.
- Bypass (with REG_WR_ARB_BYPASS_EN): accept addr 3, data 0xA5A5A5A5. Expect byp_valid=1, byp_addr=3, byp_data=0xA5A5A5A5 on the cycle rf_wen bit3 is high. For addr 0, expect byp_valid=0.
